// File: rtl/rf_pkg.sv
// Shared types and sizing for the architectural register file.
// Holds the default geometry and the address/data typedefs used by the
// register file top level and its read ports.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_DEPTH      = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
// Ports:
//   enable   - port enable; when low the port drives zero
//   addr     - entry to read
//   mem      - flattened storage array (entry i at mem[i])
//   write_en - write strobe, already qualified by reset (forwarding only)
//   waddr    - write address (forwarding only)
//   wdata    - write data (forwarding only)
//   rdata    - read data
// Optional macro RF_BYPASS_EN: forward wdata when reading the entry being
// written in the same cycle. Without it the forwarding inputs are unused.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned DEPTH      = RF_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                             enable,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
    input  logic                             write_en,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]            rdata
);

`ifdef RF_BYPASS_EN
    // Write-through: the in-flight write wins over the stored value.
    always_comb begin
        rdata = '0;
        if (enable) begin
            if (write_en && (waddr == addr)) begin
                rdata = wdata;
            end else begin
                rdata = mem[addr];
            end
        end
    end
`else
    // Forwarding inputs are intentionally ignored in this build.
    logic unused_fwd;
    assign unused_fwd = ^{write_en, waddr, wdata};

    always_comb begin
        rdata = '0;
        if (enable) begin
            rdata = mem[addr];
        end
    end
`endif

endmodule : rf_read_port

// File: rtl/register_file.sv
// Architectural register file: DEPTH x DATA_WIDTH, one synchronous write
// port, two independently enabled combinational read ports. Entry 0 is an
// ordinary writable register.
// Ports:
//   clk      - clock, all updates on the rising edge
//   reset_n  - synchronous reset, ACTIVE HIGH despite the name; clears all
//              entries and drops any simultaneous write
//   read_en  - bit p enables read port p (disabled ports drive zero)
//   write_en - write strobe
//   raddr_0/raddr_1 - read addresses
//   waddr/wdata     - write address and data
//   rdata_0/rdata_1 - combinational read data
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module register_file
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned DEPTH      = RF_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] raddr_0,
    input  logic [ADDR_WIDTH-1:0] raddr_1,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic                             wr_fire;

    // A write only takes effect outside reset; forwarding uses the same gate.
    assign wr_fire = write_en & ~reset_n;

    // Storage: reset clears everything and takes priority over a write.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            mem <= '0;
        end else if (write_en) begin
            mem[waddr] <= wdata;
        end
    end

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_0 (
        .enable   (read_en[0]),
        .addr     (raddr_0),
        .mem      (mem),
        .write_en (wr_fire),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata    (rdata_0)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_1 (
        .enable   (read_en[1]),
        .addr     (raddr_1),
        .mem      (mem),
        .write_en (wr_fire),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata    (rdata_1)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a
// randomized phase, all checked against an array-based reference model.
module tb_register_file;

    logic        clk;
    logic        reset_n;
    logic [1:0]  read_en;
    logic        write_en;
    logic [4:0]  raddr_0;
    logic [4:0]  raddr_1;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata_0;
    logic [31:0] rdata_1;

    int          n_vec;
    int          n_err;
    logic [31:0] model [32];

    register_file dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .read_en  (read_en),
        .write_en (write_en),
        .raddr_0  (raddr_0),
        .raddr_1  (raddr_1),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata_0  (rdata_0),
        .rdata_1  (rdata_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected read value from the model for the current inputs.
    function automatic logic [31:0] ref_read(input logic en, input logic [4:0] ra);
        logic [31:0] v;
        v = en ? model[ra] : 32'h0;
`ifdef RF_BYPASS_EN
        if (en && write_en && !reset_n && ra == waddr) v = wdata;
`endif
        return v;
    endfunction

    // Advance one edge, update the model, then settle just past the edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            foreach (model[i]) model[i] = 32'h0;
        end else if (write_en) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, "_p0"}, rdata_0, ref_read(read_en[0], raddr_0));
        check({tag, "_p1"}, rdata_1, ref_read(read_en[1], raddr_1));
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [31:0] d);
        write_en = 1'b1;
        waddr    = a;
        wdata    = d;
        tick();
        write_en = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] prior;
        n_vec = 0;
        n_err = 0;
        foreach (model[i]) model[i] = 32'h0;
        reset_n  = 1'b1;
        read_en  = 2'b00;
        write_en = 1'b1;
        raddr_0  = 5'd0;
        raddr_1  = 5'd0;
        waddr    = 5'd3;
        wdata    = 32'hFFFF_FFFF;

        // Reset with a competing write; the write must be dropped.
        tick();
        tick();
        reset_n  = 1'b0;
        write_en = 1'b0;
        read_en  = 2'b11;
        raddr_0  = 5'd3;
        raddr_1  = 5'd31;
        #1;
        check("reset_rd0", rdata_0, 32'h0);
        check("reset_rd1", rdata_1, 32'h0);

        // Every entry, many values, each port alone and both together.
        for (int a = 0; a < 32; a++) begin
            for (int k = 0; k < 32; k++) begin
                d = (a == 0 && k == 31) ? 32'hDEAD_BEEF : $urandom;
                write_entry(5'(a), d);
                raddr_0 = 5'(a);
                raddr_1 = 5'(a);
                read_en = 2'b01; #1; check("wr_p0only", rdata_0, d);
                read_en = 2'b10; #1; check("wr_p1only", rdata_1, d);
                read_en = 2'b11; #1;
                check("wr_both0", rdata_0, d);
                check("wr_both1", rdata_1, d);
            end
        end
        raddr_0 = 5'd0;
        read_en = 2'b01;
        #1;
        check("entry0_beef", rdata_0, 32'hDEAD_BEEF);

        // Disable gating.
        write_entry(5'd7, 32'h1234_5678);
        raddr_0 = 5'd7;
        raddr_1 = 5'd7;
        read_en = 2'b00; #1;
        check("dis_rd0", rdata_0, 32'h0);
        check("dis_rd1", rdata_1, 32'h0);
        read_en = 2'b01; #1;
        check("en01_rd0", rdata_0, 32'h1234_5678);
        check("en01_rd1", rdata_1, 32'h0);

        // Port independence and address swap.
        write_entry(5'd4, 32'hA5A5_A5A5);
        write_entry(5'd9, 32'h5A5A_5A5A);
        read_en = 2'b11;
        raddr_0 = 5'd4; raddr_1 = 5'd9; #1;
        check("ind_rd0", rdata_0, 32'hA5A5_A5A5);
        check("ind_rd1", rdata_1, 32'h5A5A_5A5A);
        raddr_0 = 5'd9; raddr_1 = 5'd4; #1;
        check("swap_rd0", rdata_0, 32'h5A5A_5A5A);
        check("swap_rd1", rdata_1, 32'hA5A5_A5A5);

        // Write strobe low must not modify storage.
        write_en = 1'b0;
        waddr    = 5'd9;
        wdata    = 32'h0;
        repeat (3) tick();
        raddr_0 = 5'd9; #1;
        check("strobe_rd0", rdata_0, 32'h5A5A_5A5A);

        // Same-cycle write/read of one entry.
        prior = 32'h1111_2222;
        write_entry(5'd12, prior);
        read_en  = 2'b01;
        raddr_0  = 5'd12;
        write_en = 1'b1;
        waddr    = 5'd12;
        wdata    = 32'hCAFE_0001;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_pre", rdata_0, 32'hCAFE_0001);
`else
        check("byp_pre", rdata_0, prior);
`endif
        tick();
        write_en = 1'b0;
        #1;
        check("byp_post", rdata_0, 32'hCAFE_0001);

        // Randomized traffic with occasional reset; addresses biased to collide.
        for (int i = 0; i < 600; i++) begin
            reset_n  = ($urandom_range(0, 39) == 0);
            write_en = 1'($urandom);
            read_en  = 2'($urandom);
            waddr    = 5'($urandom_range(0, 7));
            raddr_0  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            raddr_1  = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom);
            wdata    = $urandom;
            check_ports("rand_pre");
            tick();
            reset_n  = 1'b0;
            write_en = 1'b0;
            check_ports("rand_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_register_file
